rs232c_rx: RTL and testbench

- Asynchronous serial (RS-232C, 8N1) receiver. Turns the `rx` line into 8-bit bytes and pulses `changed` for one cycle per received byte.
- Used as the host-link receiver inside `top`. Also used in end-to-end benches to decode the design's TX line.
- Fixed bit time of `WTIME` clocks, set by a parameter.

---
 rtl/rs232c_pkg.sv | 16 +
 rtl/rs232c_rx_sync2.sv | 25 ++
 rtl/rs232c_rx.sv | 138 +++++++++++++
 tb/tb_rs232c_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rs232c_pkg.sv
// Shared types and constants for the RS-232C (8N1) receiver.
// Build option: RS232C_RX_FRAME_ERR_EN (see rs232c_rx.sv).
package rs232c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [15:0] RS232C_WTIME_SIM = 16'h0006;
    localparam int          RS232C_DATA_BITS = 8;

endpackage

// File: rtl/rs232c_rx_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous input.
// Both flops reset to 1 so a reset never looks like a start bit.
module sync2 (
    input  logic clk,
    input  logic xrst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rs232c_rx.sv
// RS-232C 8N1 receiver with a fixed bit time of WTIME clocks.
// Build option: RS232C_RX_FRAME_ERR_EN adds frame_err and drops bytes with a bad stop bit.
module rs232c_rx
    import rs232c_pkg::*;
#(
    parameter logic [15:0] WTIME = RS232C_WTIME_SIM
) (
    input  logic       clk,
    input  logic       xrst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       changed
`ifdef RS232C_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam logic [15:0] HALF = WTIME >> 1;
    localparam logic [2:0]  LAST_BIT = 3'(RS232C_DATA_BITS - 1);

    logic rxs;

    state_t state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [RS232C_DATA_BITS-1:0] shift_q, shift_d;
    logic [RS232C_DATA_BITS-1:0] data_q, data_d;
    logic changed_q, changed_d;
    logic frame_err_q, frame_err_d;
    logic timer_zero;

    sync2 u_sync_rx (
        .clk  (clk),
        .xrst (xrst),
        .d    (rx),
        .q    (rxs)
    );

    assign timer_zero = (timer_q == 16'd0);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rxs) state_d = START;
            START:     if (timer_zero) state_d = rxs ? IDLE : DATA;
            DATA:      if (timer_zero && bit_idx_q == LAST_BIT) state_d = STOP;
            STOP:      if (timer_zero) state_d = rxs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath updates driven by the current state; all sampling is mid-bit on rxs.
    always_comb begin
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        changed_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) timer_d = HALF - 16'd1;
            end
            START: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 16'd1;
                end else if (!rxs) begin
                    timer_d   = WTIME - 16'd1;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    shift_d   = {rxs, shift_q[RS232C_DATA_BITS-1:1]};
                    timer_d   = WTIME - 16'd1;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 16'd1;
                end else if (rxs) begin
                    data_d    = shift_q;
                    changed_d = 1'b1;
                end else begin
`ifdef RS232C_RX_FRAME_ERR_EN
                    frame_err_d = 1'b1;
`else
                    data_d    = shift_q;
                    changed_d = 1'b1;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            timer_q     <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            changed_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            changed_q   <= changed_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data    = data_q;
    assign changed = changed_q;
`ifdef RS232C_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_rs232c_rx.sv
// Bench for rs232c_rx: serial frames are driven, expected bytes and pulse cycles are
// queued from the frame-level rules, and a negedge monitor checks every pulse.
module tb_rs232c_rx;

    localparam int W    = 6;
    localparam int HALF = W / 2;
    // Line change after edge n: two sync flops, one IDLE edge, HALF to mid start, 9 bit times to mid stop.
    localparam int PULSE_LAT = 3 + HALF + 9 * W;

    logic       clk  = 1'b0;
    logic       xrst = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       changed;
`ifdef RS232C_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         fe_cyc_q[$];
    logic [7:0] last_data = 8'h00;
    logic       prev_changed = 1'b0;
    logic [7:0] last_good = 8'h00;

    rs232c_rx #(.WTIME(16'(W))) dut (
        .clk       (clk),
        .xrst      (xrst),
        .rx        (rx),
        .data      (data),
        .changed   (changed)
`ifdef RS232C_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!xrst) begin
            prev_changed = 1'b0;
            last_data    = data;
        end else begin
            if (changed) begin
                pulses++;
                check("changed_single_cycle", {31'd0, prev_changed}, 32'd0);
                check("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("pulse_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                    check("pulse_cycle", cyc, exp_cyc_q.pop_front());
                end
            end else begin
                check("data_hold", {24'd0, data}, {24'd0, last_data});
            end
`ifdef RS232C_RX_FRAME_ERR_EN
            if (frame_err) begin
                check("frame_err_expected", {31'd0, fe_cyc_q.size() != 0}, 32'd1);
                if (fe_cyc_q.size() != 0) check("frame_err_cycle", cyc, fe_cyc_q.pop_front());
            end
`endif
            prev_changed = changed;
            last_data    = data;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference rule: a good stop bit always delivers the byte; a bad one delivers it
    // only in the lenient build, otherwise it raises frame_err instead.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
`ifdef RS232C_RX_FRAME_ERR_EN
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_cyc_q.push_back(cyc + PULSE_LAT);
            last_good = b;
        end else begin
            fe_cyc_q.push_back(cyc + PULSE_LAT);
        end
`else
        exp_q.push_back(b);
        exp_cyc_q.push_back(cyc + PULSE_LAT);
        last_good = b;
`endif
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (W) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rb;
        int gap;
        int pulses_before;

        // Reset, then 100 idle cycles
        xrst = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1 xrst = 1'b1;
        idle(100);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_no_pulse", pulses, 0);

        // Single byte
        send_frame(8'h01, 1'b1);
        idle(5);
        check("single_byte_data", {24'd0, data}, 32'h01);
        check("single_byte_pulses", pulses, 1);

        // Back-to-back bytes with no idle gap
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        idle(3);
        check("b2b_data", {24'd0, data}, 32'h04);
        for (int i = 0; i < 4; i++) send_frame(8'hFF, 1'b1);
        idle(3);
        check("b2b_ff_data", {24'd0, data}, 32'hFF);
        check("b2b_pulses", pulses, 9);

        // Two-clock low glitch must be rejected
        pulses_before = pulses;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        check("glitch_no_pulse", pulses, pulses_before);
        send_frame(8'h14, 1'b1);
        idle(5);
        check("after_glitch_data", {24'd0, data}, 32'h14);

        // Bad stop bit, then the line held low (break)
        pulses_before = pulses;
        send_frame(8'h55, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        idle(10);
`ifdef RS232C_RX_FRAME_ERR_EN
        check("frame_err_data_kept", {24'd0, data}, 32'h14);
        check("frame_err_no_pulse", pulses, pulses_before);
`else
        check("lenient_data", {24'd0, data}, 32'h55);
        check("lenient_one_pulse", pulses, pulses_before + 1);
`endif

        // Reset in the middle of a frame, after data bit 3
        rx = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (W) @(posedge clk);
            #1;
        end
        xrst = 1'b0;
        rx   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midframe_reset_data", {24'd0, data}, 32'h00);
        check("midframe_reset_changed", {31'd0, changed}, 32'd0);
        @(posedge clk);
        #1 xrst = 1'b1;
        idle(20);
        pulses_before = pulses;
        send_frame(8'hF0, 1'b1);
        idle(5);
        check("after_reset_data", {24'd0, data}, 32'hF0);
        check("after_reset_one_pulse", pulses, pulses_before + 1);

        // Random bytes with random gaps (including none)
        for (int i = 0; i < 24; i++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 8);
            send_frame(rb, 1'b1);
            if (gap != 0) idle(gap);
        end

        for (int i = 0; i < 200 && (exp_q.size() != 0 || fe_cyc_q.size() != 0); i++) begin
            @(posedge clk);
        end
        idle(5);
        check("queue_drained", exp_q.size(), 0);
        check("fe_queue_drained", fe_cyc_q.size(), 0);
        check("final_data", {24'd0, data}, {24'd0, last_good});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
